// File: rtl/camo_pkg.sv
// Shared cell-function encodings, controller states and a sizing helper
// for the camouflaged key-load controller.
package camo_pkg;

  // Select is {s1, s0}; s0 set always means XOR regardless of s1.
  localparam logic [1:0] CAMO_NAND = 2'b00;
  localparam logic [1:0] CAMO_NOR  = 2'b10;
  localparam logic [1:0] CAMO_XOR  = 2'b?1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_COMMIT,
    LOCKED
  } camo_state_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/camo_cell.sv
// Configurable 2-input camouflaged cell: NAND, NOR or XOR chosen by a 2-bit select.
module camo_cell
  import camo_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] sel,
  output logic       y
);

  always_comb begin
    case (sel) inside
      CAMO_XOR: y = a ^ b;
      CAMO_NOR: y = ~(a | b);
      default:  y = ~(a & b);
    endcase
  end

endmodule

// File: rtl/camo_key_ctrl.sv
// Serial key loader with commit-then-lock and NCELL registered camouflaged cells.
// Optional trailing parity beat enabled by defining CAMO_KEY_PARITY_EN.
module camo_key_ctrl
  import camo_pkg::*;
#(
  parameter int NCELL = 6,
  parameter int DW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [DW-1:0]    key_data,
  input  logic             key_last,
  input  logic             commit,
  output logic             locked,
  output logic             key_err,
  input  logic [NCELL-1:0] cell_a,
  input  logic [NCELL-1:0] cell_b,
  output logic [NCELL-1:0] cell_y
);

  localparam int KW     = 2 * NCELL;
  localparam int NBEATS = ceil_div(KW, DW);
`ifdef CAMO_KEY_PARITY_EN
  localparam int LASTIDX = NBEATS;
`else
  localparam int LASTIDX = NBEATS - 1;
`endif
  localparam int CW = $clog2(LASTIDX + 1) + 1;

  camo_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KW-1:0]    shadow_q, shadow_d;
  logic [KW-1:0]    active_q, active_d;
  logic             locked_q, locked_d;
  logic             key_err_q, key_err_d;
  logic [NCELL-1:0] cell_y_q, cell_y_d;
  logic [NCELL-1:0] cell_f;
  logic             beat;
  logic             is_final;
  logic             bad;

  assign key_ready = (state_q == IDLE) || (state_q == LOAD);
  assign beat      = key_valid && key_ready;
  assign is_final  = (int'(cnt_q) == LASTIDX);

  for (genvar i = 0; i < NCELL; i++) begin : g_cell
    camo_cell u_cell (
      .a   (cell_a[i]),
      .b   (cell_b[i]),
      .sel ({active_q[2*i+1], active_q[2*i]}),
      .y   (cell_f[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    locked_d  = locked_q;
    key_err_d = 1'b0;
    cell_y_d  = cell_f;
    bad       = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        if (beat) begin
          // Only key bits fall in a beat's window; the parity beat and any
          // excess bits of the final beat map onto no shadow bit.
          for (int k = 0; k < KW; k++) begin
            if (k / DW == int'(cnt_q)) shadow_d[k] = key_data[k % DW];
          end
          bad = (key_last != is_final);
`ifdef CAMO_KEY_PARITY_EN
          if (is_final && (key_data[0] != ^shadow_q)) bad = 1'b1;
`endif
          if (bad) begin
            shadow_d  = '0;
            cnt_d     = '0;
            state_d   = IDLE;
            key_err_d = 1'b1;
          end else if (is_final) begin
            cnt_d   = '0;
            state_d = WAIT_COMMIT;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      WAIT_COMMIT: begin
        if (commit) begin
          active_d = shadow_q;
          locked_d = 1'b1;
          state_d  = LOCKED;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      locked_q  <= 1'b0;
      key_err_q <= 1'b0;
      cell_y_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      locked_q  <= locked_d;
      key_err_q <= key_err_d;
      cell_y_q  <= cell_y_d;
    end
  end

  assign locked  = locked_q;
  assign key_err = key_err_q;
  assign cell_y  = cell_y_q;

endmodule

// File: tb/tb_camo_key_ctrl.sv
// Self-checking bench for camo_key_ctrl: directed protocol steps plus random keys
// checked against a behavioural cell-function model.
module tb_camo_key_ctrl;

  localparam int NCELL = 6;
  localparam int DW    = 4;
  localparam int KW    = 2 * NCELL;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_valid = 1'b0;
  logic             key_ready;
  logic [DW-1:0]    key_data = '0;
  logic             key_last = 1'b0;
  logic             commit = 1'b0;
  logic             locked;
  logic             key_err;
  logic [NCELL-1:0] cell_a = '0;
  logic [NCELL-1:0] cell_b = '0;
  logic [NCELL-1:0] cell_y;

  int n_cmp = 0;
  int n_err = 0;

  camo_key_ctrl #(.NCELL(NCELL), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_data  (key_data),
    .key_last  (key_last),
    .commit    (commit),
    .locked    (locked),
    .key_err   (key_err),
    .cell_a    (cell_a),
    .cell_b    (cell_b),
    .cell_y    (cell_y)
  );

  always #5 clk = ~clk;

  // Cell i: s0 = key[2i] selects XOR; otherwise s1 picks NOR (1) or NAND (0).
  function automatic logic [NCELL-1:0] model_y(input logic [KW-1:0] key,
                                               input logic [NCELL-1:0] a,
                                               input logic [NCELL-1:0] b);
    logic [NCELL-1:0] r;
    for (int i = 0; i < NCELL; i++) begin
      if (key[2*i])        r[i] = a[i] ^ b[i];
      else if (key[2*i+1]) r[i] = ~(a[i] | b[i]);
      else                 r[i] = ~(a[i] & b[i]);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    key_valid = 1'b0;
    key_last  = 1'b0;
    commit    = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    key_valid = 1'b1;
    key_data  = d;
    key_last  = last;
    @(negedge clk);
    key_valid = 1'b0;
    key_last  = 1'b0;
  endtask

  // gap_mode: 0 none, 1 one idle cycle after the first beat, 2 random gaps
  task automatic load_key(input logic [KW-1:0] key, input int gap_mode);
    int nb;
    nb = (KW + DW - 1) / DW;
    for (int bt = 0; bt < nb; bt++) begin
      if ((gap_mode == 1 && bt == 1) || (gap_mode == 2 && $urandom_range(1, 0) == 1))
        @(negedge clk);
`ifdef CAMO_KEY_PARITY_EN
      send_beat(key[bt*DW +: DW], 1'b0);
`else
      send_beat(key[bt*DW +: DW], bt == nb - 1);
`endif
    end
`ifdef CAMO_KEY_PARITY_EN
    send_beat({{(DW-1){1'b0}}, ^key}, 1'b1);
`endif
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    chk("commit_locked", 32'(locked), 32'd1);
    chk("commit_ready", 32'(key_ready), 32'd0);
  endtask

  task automatic check_cells(input string tag, input logic [KW-1:0] key, input int n);
    for (int i = 0; i < n; i++) begin
      cell_a = NCELL'($urandom);
      cell_b = NCELL'($urandom);
      @(negedge clk);
      chk(tag, 32'(cell_y), 32'(model_y(key, cell_a, cell_b)));
    end
  endtask

  initial begin
    logic [KW-1:0] key;

    do_reset();
    chk("rst_ready", 32'(key_ready), 32'd1);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(key_err), 32'd0);
    chk("rst_cell_y", 32'(cell_y), 32'd0);
    cell_a = '1;
    cell_b = '1;
    @(negedge clk);
    chk("nand_ones", 32'(cell_y), 32'h00);
    check_cells("pre_commit_nand", '0, 3);

    // Directed key: NAND, XOR, XOR, XOR, NOR, NOR
    load_key(12'hA5C, 0);
    chk("wait_ready", 32'(key_ready), 32'd0);
    chk("wait_locked", 32'(locked), 32'd0);
    do_commit();
    cell_a = '0;
    cell_b = '0;
    @(negedge clk);
    chk("a5c_zeros", 32'(cell_y), 32'b110001);
    check_cells("a5c_rand", 12'hA5C, 4);

    // Locked: further beats refused, key unchanged
    for (int i = 0; i < 10; i++) begin
      key_valid = 1'b1;
      key_data  = DW'($urandom);
      key_last  = 1'($urandom);
      cell_a    = NCELL'($urandom);
      cell_b    = NCELL'($urandom);
      @(negedge clk);
      chk("lock_ready", 32'(key_ready), 32'd0);
      chk("lock_cells", 32'(cell_y), 32'(model_y(12'hA5C, cell_a, cell_b)));
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(key_ready), 32'd1);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_err", 32'(key_err), 32'd0);
    chk("midrst_cell_y", 32'(cell_y), 32'd0);
    key_valid = 1'b0;
    key_last  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Early key_last
    send_beat(4'h1, 1'b0);
    send_beat(4'h2, 1'b1);
    chk("early_err", 32'(key_err), 32'd1);
    chk("early_idle", 32'(key_ready), 32'd1);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    chk("early_err_pulse", 32'(key_err), 32'd0);
    chk("early_no_lock", 32'(locked), 32'd0);
    key = KW'($urandom);
    load_key(key, 0);
    do_commit();
    check_cells("after_err", key, 3);

`ifndef CAMO_KEY_PARITY_EN
    // Missing key_last on final beat
    do_reset();
    send_beat(4'h3, 1'b0);
    send_beat(4'h4, 1'b0);
    send_beat(4'h5, 1'b0);
    chk("nolast_err", 32'(key_err), 32'd1);
    chk("nolast_idle", 32'(key_ready), 32'd1);
    @(negedge clk);
    chk("nolast_pulse", 32'(key_err), 32'd0);
`else
    // Parity beat mismatch, then match
    do_reset();
    send_beat(4'hC, 1'b0);
    send_beat(4'h5, 1'b0);
    send_beat(4'hA, 1'b0);
    send_beat({3'b0, ~(^12'hA5C)}, 1'b1);
    chk("par_bad_err", 32'(key_err), 32'd1);
    chk("par_bad_idle", 32'(key_ready), 32'd1);
    load_key(12'hA5C, 0);
    chk("par_ok_wait", 32'(key_ready), 32'd0);
    chk("par_ok_noerr", 32'(key_err), 32'd0);
`endif

    // Gap between first and second beat
    do_reset();
    load_key(12'hA5C, 1);
    chk("gap_wait", 32'(key_ready), 32'd0);
    do_commit();
    check_cells("gap_cells", 12'hA5C, 3);

    // Reset mid-load, then a clean load
    do_reset();
    send_beat(4'hF, 1'b0);
    send_beat(4'hF, 1'b0);
    do_reset();
    key = KW'($urandom);
    load_key(key, 0);
    do_commit();
    check_cells("midload_rst", key, 3);

    // Random keys with random gaps
    for (int it = 0; it < 15; it++) begin
      do_reset();
      key = KW'($urandom);
      load_key(key, 2);
      chk("rnd_wait", 32'(key_ready), 32'd0);
      check_cells("rnd_pre", '0, 2);
      do_commit();
      check_cells("rnd_post", key, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
